// File: rtl/td4x_core.sv
// TD4-compatible CPU core with parametrised data/PC width, writable program memory,
// single-step execution and self-jump halt detection.
module td4x_core #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [DATA_W+3:0] prog_data,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic [PC_W-1:0]   pc,
  output logic              carry,
  output logic              halted
);

  localparam int unsigned Depth = 2 ** PC_W;

  typedef enum logic [3:0] {
    OpAddA = 4'b0000,
    OpMovAB = 4'b0001,
    OpInA  = 4'b0010,
    OpMovA = 4'b0011,
    OpMovBA = 4'b0100,
    OpAddB = 4'b0101,
    OpInB  = 4'b0110,
    OpMovB = 4'b0111,
    OpOutB = 4'b1001,
    OpOutIm = 4'b1011,
    OpJnc  = 4'b1110,
    OpJmp  = 4'b1111
  } opcode_e;

  logic [DATA_W+3:0] mem_q [Depth];

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              c_q, c_d, halted_q, halted_d;

  logic [DATA_W+3:0] instr;
  opcode_e           op;
  logic [DATA_W-1:0] im;
  logic [PC_W-1:0]   target, pc_inc;
  logic [DATA_W:0]   sum;
  logic              exec;

  assign exec   = (run | step) & ~halted_q;
  assign instr  = mem_q[pc_q];
  assign op     = opcode_e'(instr[DATA_W+3:DATA_W]);
  assign im     = instr[DATA_W-1:0];
  assign target = im[PC_W-1:0];
  assign pc_inc = pc_q + PC_W'(1);
  assign sum    = {1'b0, (op == OpAddB) ? b_q : a_q} + {1'b0, im};

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    pc_d     = pc_q;
    c_d      = c_q;
    halted_d = halted_q;
    if (exec) begin
      pc_d = pc_inc;
      c_d  = 1'b0;
      unique case (op)
        OpAddA: begin
          a_d = sum[DATA_W-1:0];
          c_d = sum[DATA_W];
        end
        OpAddB: begin
          b_d = sum[DATA_W-1:0];
          c_d = sum[DATA_W];
        end
        OpMovA:  a_d = im;
        OpMovB:  b_d = im;
        OpMovAB: a_d = b_q;
        OpMovBA: b_d = a_q;
        OpInA:   a_d = in_port;
        OpInB:   b_d = in_port;
        OpOutB:  out_d = b_q;
        OpOutIm: out_d = im;
        OpJmp: begin
          pc_d     = target;
          halted_d = (target == pc_q);
        end
        OpJnc: begin
          // Jump decision uses the carry produced by the previous instruction.
          if (!c_q) begin
            pc_d     = target;
            halted_d = (target == pc_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      pc_q     <= '0;
      c_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      pc_q     <= pc_d;
      c_q      <= c_d;
      halted_q <= halted_d;
    end
  end

  // No reset on the array so a program loaded before reset survives it.
  always_ff @(posedge clk) begin
    if (!rst && prog_we && !run) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign out_port = out_q;
  assign pc       = pc_q;
  assign carry    = c_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_td4x_core.sv
// Scoreboard bench for td4x_core: a 4/4 instance and an 8/6 instance run directed programs.
module tb_td4x_core;

  localparam int SOut = 0, SPc = 1, SC = 2, SH = 3, SA = 4, SB = 5;

  typedef struct {
    string       name;
    int          dut;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, run4, step4, we4, c4, h4;
  logic [3:0] addr4, in4, out4, pc4;
  logic [7:0] data4;

  logic       rst8, run8, step8, we8, c8, h8;
  logic [5:0] addr8, pc8;
  logic [11:0] data8;
  logic [7:0] in8, out8;

  td4x_core #(.DATA_W(4), .PC_W(4)) d4 (
    .clk(clk), .rst(rst4), .run(run4), .step(step4), .prog_we(we4), .prog_addr(addr4),
    .prog_data(data4), .in_port(in4), .out_port(out4), .pc(pc4), .carry(c4), .halted(h4)
  );

  td4x_core #(.DATA_W(8), .PC_W(6)) d8 (
    .clk(clk), .rst(rst8), .run(run8), .step(step8), .prog_we(we8), .prog_addr(addr8),
    .prog_data(data8), .in_port(in8), .out_port(out8), .pc(pc8), .carry(c8), .halted(h8)
  );

  function automatic logic [15:0] actual(input int d, input int s);
    if (d == 0) begin
      case (s)
        SOut:    return 16'(out4);
        SPc:     return 16'(pc4);
        SC:      return 16'(c4);
        SH:      return 16'(h4);
        SA:      return 16'(d4.a_q);
        default: return 16'(d4.b_q);
      endcase
    end else begin
      case (s)
        SOut:    return 16'(out8);
        SPc:     return 16'(pc8);
        SC:      return 16'(c8);
        SH:      return 16'(h8);
        SA:      return 16'(d8.a_q);
        default: return 16'(d8.b_q);
      endcase
    end
  endfunction

  // Monitor: drains everything queued since the last active edge.
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] act;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      act = actual(e.dut, e.sel);
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, want 0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic chk(input string n, input int d, input int s, input logic [15:0] v);
    exp_t e;
    e.name = n;
    e.dut  = d;
    e.sel  = s;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [3:0] a, input logic [7:0] w);
    we4 = 1'b1; addr4 = a; data4 = w;
    tick();
    we4 = 1'b0;
  endtask

  task automatic load8(input logic [5:0] a, input logic [11:0] w);
    we8 = 1'b1; addr8 = a; data8 = w;
    tick();
    we8 = 1'b0;
  endtask

  logic [7:0] p1 [5] = '{8'h33, 8'h0E, 8'hE0, 8'hB9, 8'hF4};
  logic [7:0] p2 [7] = '{8'h75, 8'h01, 8'hE1, 8'h91, 8'h40, 8'h91, 8'hF6};

  initial begin
    #50000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst4 = 1'b1; run4 = 1'b0; step4 = 1'b0; we4 = 1'b0; addr4 = '0; data4 = '0; in4 = '0;
    rst8 = 1'b1; run8 = 1'b0; step8 = 1'b0; we8 = 1'b0; addr8 = '0; data8 = '0; in8 = '0;
    tick();
    rst4 = 1'b0; rst8 = 1'b0;
    chk("rst_out", 0, SOut, 0); chk("rst_pc", 0, SPc, 0);
    chk("rst_carry", 0, SC, 0); chk("rst_halt", 0, SH, 0);
    chk("rst8_pc", 1, SPc, 0);  chk("rst8_out", 1, SOut, 0);

    // Straight-line program ending in a self-jump.
    for (int i = 0; i < 5; i++) load4(4'(i), p1[i]);
    run4 = 1'b1;
    tick(); chk("p1_a0", 0, SA, 3); chk("p1_pc0", 0, SPc, 1);
    tick(); chk("p1_a1", 0, SA, 1); chk("p1_c1", 0, SC, 1); chk("p1_pc1", 0, SPc, 2);
    tick(); chk("p1_jnc_pc", 0, SPc, 3); chk("p1_jnc_c", 0, SC, 0);
    tick(); chk("p1_out", 0, SOut, 9); chk("p1_pc3", 0, SPc, 4);
    tick(); chk("p1_halt", 0, SH, 1); chk("p1_halt_pc", 0, SPc, 4);

    // Write while run=1 must be dropped.
    we4 = 1'b1; addr4 = 4'd0; data4 = 8'hB5;
    tick(); we4 = 1'b0;
    chk("halt_hold_pc", 0, SPc, 4); chk("halt_hold", 0, SH, 1); chk("halt_hold_out", 0, SOut, 9);

    rst4 = 1'b1;
    tick(); run4 = 1'b0; rst4 = 1'b0;
    chk("rst2_pc", 0, SPc, 0); chk("rst2_halt", 0, SH, 0); chk("rst2_out", 0, SOut, 0);
    chk("rst2_a", 0, SA, 0);
    step4 = 1'b1;
    tick(); step4 = 1'b0;
    chk("we_run_ign_a", 0, SA, 3); chk("we_run_ign_out", 0, SOut, 0); chk("we_run_ign_pc", 0, SPc, 1);

    // Reset in the middle of a running program.
    rst4 = 1'b1;
    tick(); rst4 = 1'b0; run4 = 1'b1;
    repeat (3) tick();
    chk("mid_a", 0, SA, 1); chk("mid_pc", 0, SPc, 3);
    rst4 = 1'b1;
    tick(); rst4 = 1'b0; run4 = 1'b0;
    chk("mid_rst_pc", 0, SPc, 0); chk("mid_rst_a", 0, SA, 0);

    // Counter loop: JNC 1 exits once A wraps 15 -> 0.
    for (int i = 0; i < 7; i++) load4(4'(i), p2[i]);
    rst4 = 1'b1;
    tick(); rst4 = 1'b0; run4 = 1'b1;
    repeat (31) tick();
    chk("loop_a15", 0, SA, 15); chk("loop_pc1", 0, SPc, 1); chk("loop_c0", 0, SC, 0);
    tick(); chk("loop_wrap_a", 0, SA, 0); chk("loop_wrap_c", 0, SC, 1); chk("loop_pc2", 0, SPc, 2);
    tick(); chk("loop_exit_pc", 0, SPc, 3); chk("loop_exit_c", 0, SC, 0);
    tick(); chk("loop_out_b", 0, SOut, 5);
    for (int i = 0; i < 10 && !h4; i++) tick();
    chk("loop_halt", 0, SH, 1); chk("loop_halt_pc", 0, SPc, 6);
    chk("loop_out0", 0, SOut, 0); chk("loop_b0", 0, SB, 0);
    run4 = 1'b0;

    // Single-step mode.
    rst4 = 1'b1;
    tick(); rst4 = 1'b0;
    load4(4'd0, 8'h3A); load4(4'd1, 8'h0F);
    step4 = 1'b1;
    tick(); step4 = 1'b0;
    chk("st1_a", 0, SA, 4'hA); chk("st1_pc", 0, SPc, 1); chk("st1_c", 0, SC, 0);
    repeat (3) tick();
    chk("idle_a", 0, SA, 4'hA); chk("idle_pc", 0, SPc, 1); chk("idle_c", 0, SC, 0);
    step4 = 1'b1;
    tick(); step4 = 1'b0;
    chk("st2_a", 0, SA, 9); chk("st2_c", 0, SC, 1); chk("st2_pc", 0, SPc, 2);
    step4 = 1'b1;
    tick(); tick(); step4 = 1'b0;
    chk("st_held_pc", 0, SPc, 4); chk("st_held_c", 0, SC, 0);

    // Step with a write to the current PC: old word (MOV B,A) executes.
    step4 = 1'b1; we4 = 1'b1; addr4 = 4'd4; data4 = 8'hBC;
    tick(); step4 = 1'b0; we4 = 1'b0;
    chk("stw_b", 0, SB, 9); chk("stw_out", 0, SOut, 0); chk("stw_pc", 0, SPc, 5);
    load4(4'd5, 8'hF4);
    step4 = 1'b1;
    tick(); chk("jmp_back_pc", 0, SPc, 4); chk("jmp_back_halt", 0, SH, 0);
    tick(); step4 = 1'b0;
    chk("new_word_out", 0, SOut, 4'hC); chk("new_word_pc", 0, SPc, 5);
    load4(4'd5, 8'hE5);
    step4 = 1'b1;
    tick(); chk("jnc_halt", 0, SH, 1); chk("jnc_halt_pc", 0, SPc, 5);
    tick(); step4 = 1'b0;
    chk("jnc_hold_pc", 0, SPc, 5); chk("jnc_hold_out", 0, SOut, 4'hC);

    // Wide instance: 8-bit carry, IN/OUT, PC wrap at 63.
    load8(6'd0, 12'h301); load8(6'd1, 12'h0FF); load8(6'd2, 12'h600); load8(6'd3, 12'h900);
    for (int i = 4; i < 64; i++) load8(6'(i), 12'h800);
    in8 = 8'hA5; run8 = 1'b1;
    tick(); chk("w_a1", 1, SA, 1); chk("w_pc1", 1, SPc, 1);
    tick(); chk("w_add_a", 1, SA, 0); chk("w_add_c", 1, SC, 1); chk("w_pc2", 1, SPc, 2);
    tick(); chk("w_in_b", 1, SB, 8'hA5); chk("w_in_c", 1, SC, 0);
    tick(); chk("w_out", 1, SOut, 8'hA5); chk("w_pc4", 1, SPc, 4);
    repeat (59) tick();
    chk("w_pc63", 1, SPc, 63);
    tick(); chk("w_wrap_pc", 1, SPc, 0);
    tick(); chk("w_rerun_a", 1, SA, 1); chk("w_rerun_pc", 1, SPc, 1); chk("w_no_halt", 1, SH, 0);
    run8 = 1'b0;

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
